// File: rtl/altair_bus_pkg.sv
// ---------------------------------------------------------------------------
// altair_bus_pkg
// Shared definitions for the memory bus arbiter slice:
//   - bus_state_t : access sequencer states (ARB -> ACCESS -> RESP)
//   - OWNER_CPU / OWNER_DMA : owner encoding, also used as the master index
//     (master 0 = i8080 core, master 1 = DMA/loader)
//   - NUM_MASTERS : number of masters sharing the slave
// ---------------------------------------------------------------------------
package altair_bus_pkg;

    typedef enum logic [1:0] {
        ST_ARB    = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } bus_state_t;

    localparam logic OWNER_CPU = 1'b0;
    localparam logic OWNER_DMA = 1'b1;

    localparam int NUM_MASTERS = 2;

    // Opposite owner, used for the plain round-robin hand-over.
    function automatic logic other_owner(input logic cur);
        return ~cur;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter between the CPU (owner 0) and DMA (owner 1)
// with a DMA lock that allows a bounded run of back-to-back DMA grants.
//
// Ports:
//   clk          in   system clock
//   reset_n      in   asynchronous active-low reset
//   arb_en       in   arbitration window (sequencer is in ARB)
//   cpu_req      in   CPU request
//   dma_req      in   DMA request
//   dma_lock     in   DMA lock, sampled at the grant
//   grant_valid  out  a grant is issued this cycle (combinational)
//   grant_owner  out  owner being granted this cycle (combinational)
//   owner        out  registered owner of the current/last access
// ---------------------------------------------------------------------------
module rr_arb2
    import altair_bus_pkg::*;
#(
    parameter int MAX_BURST = 8
) (
    input  logic clk,
    input  logic reset_n,
    input  logic arb_en,
    input  logic cpu_req,
    input  logic dma_req,
    input  logic dma_lock,
    output logic grant_valid,
    output logic grant_owner,
    output logic owner
);

    localparam int              CW        = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0]   BURST_MAX = CW'(MAX_BURST);

    logic          owner_reg, owner_next;
    logic [CW-1:0] burst_cnt_reg, burst_cnt_next;
    logic          lock_hold;
    logic          dma_chain;

    // DMA keeps the bus under contention only while it owned the last access,
    // still asserts lock, and has not yet used up its burst allowance.
    assign lock_hold = (owner_reg == OWNER_DMA) && dma_lock && (burst_cnt_reg < BURST_MAX);

    always_comb begin
        grant_valid    = arb_en && (cpu_req || dma_req);
        grant_owner    = OWNER_CPU;
        owner_next     = owner_reg;
        burst_cnt_next = burst_cnt_reg;
        dma_chain      = 1'b0;

        if (cpu_req && dma_req) begin
            grant_owner = lock_hold ? OWNER_DMA : other_owner(owner_reg);
        end else if (dma_req) begin
            grant_owner = OWNER_DMA;
        end else begin
            grant_owner = OWNER_CPU;
        end

        if (grant_valid) begin
            owner_next = grant_owner;
            // A locked DMA grant following a DMA access extends the burst;
            // any other grant starts counting from scratch.
            dma_chain = (grant_owner == OWNER_DMA) && (owner_reg == OWNER_DMA) && dma_lock;
            if (dma_chain) begin
                if (burst_cnt_reg < BURST_MAX) begin
                    burst_cnt_next = burst_cnt_reg + CW'(1);
                end
            end else begin
                burst_cnt_next = '0;
            end
        end
    end

    // Owner resets to DMA so the CPU wins the first contention.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            owner_reg     <= OWNER_DMA;
            burst_cnt_reg <= '0;
        end else begin
            owner_reg     <= owner_next;
            burst_cnt_reg <= burst_cnt_next;
        end
    end

    assign owner = owner_reg;

endmodule

// File: rtl/mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// mem_bus_arbiter
// Shares one synchronous single-port memory slave between the i8080 core
// (CPU, master 0) and a DMA/loader master (master 1). Each access runs
// ARB -> ACCESS -> RESP: the grant is taken in ARB, the slave strobe is high
// for the single ACCESS cycle, and the owner's ack pulses in RESP together
// with read data. Request seen in ARB cycle N gives ack in cycle N+2.
//
// Ports:
//   clk, reset_n                     clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata            CPU request, held until cpu_ack
//   cpu_rdata, cpu_ack               CPU read data (valid with ack), ack pulse
//   dma_req/lock/we/addr/wdata       DMA request; lock sampled at grant
//   dma_rdata, dma_ack               DMA read data (valid with ack), ack pulse
//   mem_addr, mem_wdata              registered slave address / write data
//   mem_rd, mem_we                   one-cycle slave read / write strobes
//   mem_rdata                        slave read data, valid cycle after mem_rd
//   owner                            0=CPU, 1=DMA, owner of current/last access
//   busy                             high in ACCESS and RESP
// ---------------------------------------------------------------------------
module mem_bus_arbiter
    import altair_bus_pkg::*;
#(
    parameter int AW        = 16,
    parameter int MAX_BURST = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          cpu_req,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [7:0]    cpu_wdata,
    output logic [7:0]    cpu_rdata,
    output logic          cpu_ack,
    input  logic          dma_req,
    input  logic          dma_lock,
    input  logic          dma_we,
    input  logic [AW-1:0] dma_addr,
    input  logic [7:0]    dma_wdata,
    output logic [7:0]    dma_rdata,
    output logic          dma_ack,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    output logic          mem_rd,
    output logic          mem_we,
    input  logic [7:0]    mem_rdata,
    output logic          owner,
    output logic          busy
);

    bus_state_t state_reg, state_next;

    logic arb_en;
    logic grant_valid;
    logic grant_owner;
    logic owner_cur;

    // Per-master views, indexed by owner encoding.
    logic [NUM_MASTERS-1:0]         we_vec;
    logic [NUM_MASTERS-1:0][AW-1:0] addr_vec;
    logic [NUM_MASTERS-1:0][7:0]    wdata_vec;
    logic [NUM_MASTERS-1:0]         ack_vec;
    logic [NUM_MASTERS-1:0][7:0]    rdata_vec;

    logic [AW-1:0] addr_reg;
    logic [7:0]    wdata_reg;
    logic          we_reg;

    assign we_vec[OWNER_CPU]    = cpu_we;
    assign we_vec[OWNER_DMA]    = dma_we;
    assign addr_vec[OWNER_CPU]  = cpu_addr;
    assign addr_vec[OWNER_DMA]  = dma_addr;
    assign wdata_vec[OWNER_CPU] = cpu_wdata;
    assign wdata_vec[OWNER_DMA] = dma_wdata;

    // -----------------------------------------------------------------------
    // Arbitration
    // -----------------------------------------------------------------------
    assign arb_en = (state_reg == ST_ARB);

    rr_arb2 #(
        .MAX_BURST (MAX_BURST)
    ) u_arb (
        .clk         (clk),
        .reset_n     (reset_n),
        .arb_en      (arb_en),
        .cpu_req     (cpu_req),
        .dma_req     (dma_req),
        .dma_lock    (dma_lock),
        .grant_valid (grant_valid),
        .grant_owner (grant_owner),
        .owner       (owner_cur)
    );

    // -----------------------------------------------------------------------
    // Access sequencer
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg <= ST_ARB;
        end else begin
            state_reg <= state_next;
        end
    end

    // Strobes decode straight from the state register so an asynchronous
    // reset removes them immediately, without waiting for a clock edge.
    always_comb begin
        state_next = state_reg;
        mem_rd     = 1'b0;
        mem_we     = 1'b0;
        busy       = 1'b0;
        case (state_reg)
            ST_ARB: begin
                if (grant_valid) begin
                    state_next = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                mem_rd     = ~we_reg;
                mem_we     = we_reg;
                busy       = 1'b1;
                state_next = ST_RESP;
            end
            ST_RESP: begin
                busy       = 1'b1;
                state_next = ST_ARB;
            end
            default: begin
                state_next = ST_ARB;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Request capture: the winning master's command is frozen at grant, so a
    // master dropping or changing its request mid-access has no effect.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            addr_reg  <= '0;
            wdata_reg <= '0;
            we_reg    <= 1'b0;
        end else if (grant_valid) begin
            addr_reg  <= addr_vec[grant_owner];
            wdata_reg <= wdata_vec[grant_owner];
            we_reg    <= we_vec[grant_owner];
        end
    end

    assign mem_addr  = addr_reg;
    assign mem_wdata = wdata_reg;
    assign owner     = owner_cur;

    // -----------------------------------------------------------------------
    // Per-master response path. The slave delivers read data during RESP, so
    // it is forwarded in the ack cycle and captured for holding afterwards.
    // -----------------------------------------------------------------------
    genvar gi;
    generate
        for (gi = 0; gi < NUM_MASTERS; gi++) begin : g_master
            logic       rd_resp;
            logic [7:0] rdata_reg;

            assign ack_vec[gi] = (state_reg == ST_RESP) && (owner_cur == 1'(gi));
            assign rd_resp     = ack_vec[gi] && !we_reg;

            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    rdata_reg <= '0;
                end else if (rd_resp) begin
                    rdata_reg <= mem_rdata;
                end
            end

            assign rdata_vec[gi] = rd_resp ? mem_rdata : rdata_reg;
        end
    endgenerate

    assign cpu_ack   = ack_vec[OWNER_CPU];
    assign dma_ack   = ack_vec[OWNER_DMA];
    assign cpu_rdata = rdata_vec[OWNER_CPU];
    assign dma_rdata = rdata_vec[OWNER_DMA];

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_bus_arbiter
// Self-checking bench for mem_bus_arbiter: a table of single accesses from
// idle, hand-written arbitration sequences (alternation, locked bursts,
// burst saturation, reset mid-access), then random traffic from two master
// agents checked against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_mem_bus_arbiter;

    localparam int AW   = 16;
    localparam int MAXB = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic          cpu_req, cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [7:0]    cpu_wdata, cpu_rdata;
    logic          cpu_ack;
    logic          dma_req, dma_lock, dma_we;
    logic [AW-1:0] dma_addr;
    logic [7:0]    dma_wdata, dma_rdata;
    logic          dma_ack;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic          mem_rd, mem_we;
    logic [7:0]    mem_rdata = 8'h00;
    logic          owner, busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_bus_arbiter #(.AW(AW), .MAX_BURST(MAXB)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cpu_req   (cpu_req),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .dma_req   (dma_req),
        .dma_lock  (dma_lock),
        .dma_we    (dma_we),
        .dma_addr  (dma_addr),
        .dma_wdata (dma_wdata),
        .dma_rdata (dma_rdata),
        .dma_ack   (dma_ack),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_we    (mem_we),
        .mem_rdata (mem_rdata),
        .owner     (owner),
        .busy      (busy)
    );

    // Synchronous slave: 16 bytes, indexed by the low address nibble.
    logic [7:0] slave_mem [16];
    always @(posedge clk) begin
        if (mem_we) slave_mem[mem_addr[3:0]] <= mem_wdata;
        if (mem_rd) mem_rdata <= slave_mem[mem_addr[3:0]];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Exclusivity holds in every cycle regardless of what the test is doing.
    always @(negedge clk) begin
        chk("ack_overlap", 32'(cpu_ack & dma_ack), 32'd0);
        chk("strobe_overlap", 32'(mem_rd & mem_we), 32'd0);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset_n   = 1'b0;
        cpu_req   = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        dma_req   = 1'b0; dma_we = 1'b0; dma_addr = '0; dma_wdata = '0;
        dma_lock  = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
    endtask

    // Hold request levels and record which master each ack goes to.
    task automatic run_seq(input logic c_on, input logic d_on, input logic lock,
                           input int n, input logic [31:0] exp_bits, input string tag);
        int got = 0;
        cpu_req  = c_on; cpu_we = 1'b0; cpu_addr = 16'h0011;
        dma_req  = d_on; dma_we = 1'b0; dma_addr = 16'h0022;
        dma_lock = lock;
        for (int cyc = 0; (cyc < 40 * n) && (got < n); cyc++) begin
            tick;
            if (cpu_ack || dma_ack) begin
                chk($sformatf("%s_grant%0d", tag, got), 32'(dma_ack), 32'(exp_bits[got]));
                $display("%s ack %0d -> %s", tag, got, dma_ack ? "DMA" : "CPU");
                got++;
            end
        end
        chk($sformatf("%s_count", tag), 32'(got), 32'(n));
    endtask

    typedef struct {
        logic        dma;
        logic        we;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  exp_rdata;
    } vec_t;

    vec_t vecs [7];

    // Reference model state for the random phase.
    logic [7:0]  shadow [16];
    bit          m_owner;
    int          m_burst;
    int          free_at;
    bit          p_valid, p_dma, p_we;
    int          p_ack_t;
    logic [15:0] p_addr;
    logic [7:0]  p_wdata, p_rdata;
    logic [7:0]  e_cpu_rdata, e_dma_rdata;
    bit          ca, da;
    bit          e_cpu_ack, e_dma_ack, e_strobe, w;
    int          n_txn;

    function automatic bit pick(bit c, bit d, bit lock, bit last, int burst);
        if (c && !d) return 1'b0;
        if (d && !c) return 1'b1;
        if (last && lock && burst < MAXB) return 1'b1;
        return !last;
    endfunction

    initial begin
        vecs[0] = '{dma:1'b0, we:1'b0, addr:16'h1234, wdata:8'h00, exp_rdata:8'hA5};
        vecs[1] = '{dma:1'b1, we:1'b1, addr:16'h1F00, wdata:8'h3C, exp_rdata:8'h00};
        vecs[2] = '{dma:1'b0, we:1'b1, addr:16'h0007, wdata:8'h5A, exp_rdata:8'h00};
        vecs[3] = '{dma:1'b1, we:1'b0, addr:16'h0007, wdata:8'h00, exp_rdata:8'h5A};
        vecs[4] = '{dma:1'b0, we:1'b0, addr:16'hFFFF, wdata:8'h00, exp_rdata:8'hE1};
        vecs[5] = '{dma:1'b1, we:1'b0, addr:16'hAB00, wdata:8'h00, exp_rdata:8'h3C};
        vecs[6] = '{dma:1'b0, we:1'b0, addr:16'h0003, wdata:8'h00, exp_rdata:8'h33};

        for (int i = 0; i < 16; i++) slave_mem[i] = 8'(i * 17);
        slave_mem[4]  = 8'hA5;
        slave_mem[15] = 8'hE1;

        // ---------------- reset state ----------------
        do_reset;
        chk("rst_cpu_ack",   32'(cpu_ack),   32'd0);
        chk("rst_dma_ack",   32'(dma_ack),   32'd0);
        chk("rst_mem_rd",    32'(mem_rd),    32'd0);
        chk("rst_mem_we",    32'(mem_we),    32'd0);
        chk("rst_mem_addr",  32'(mem_addr),  32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_cpu_rdata", 32'(cpu_rdata), 32'd0);
        chk("rst_dma_rdata", 32'(dma_rdata), 32'd0);
        chk("rst_owner",     32'(owner),     32'd1);
        chk("rst_busy",      32'(busy),      32'd0);

        // ---------------- single accesses from idle ----------------
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].dma) begin
                dma_req = 1'b1; dma_we = vecs[i].we; dma_addr = vecs[i].addr; dma_wdata = vecs[i].wdata;
            end else begin
                cpu_req = 1'b1; cpu_we = vecs[i].we; cpu_addr = vecs[i].addr; cpu_wdata = vecs[i].wdata;
            end
            tick; // N+1: ACCESS
            chk($sformatf("v%0d_mem_rd", i),   32'(mem_rd),   32'(!vecs[i].we));
            chk($sformatf("v%0d_mem_we", i),   32'(mem_we),   32'(vecs[i].we));
            chk($sformatf("v%0d_mem_addr", i), 32'(mem_addr), 32'(vecs[i].addr));
            chk($sformatf("v%0d_owner", i),    32'(owner),    32'(vecs[i].dma));
            chk($sformatf("v%0d_busy1", i),    32'(busy),     32'd1);
            chk($sformatf("v%0d_early_ack", i), 32'(cpu_ack | dma_ack), 32'd0);
            if (vecs[i].we) chk($sformatf("v%0d_mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].wdata));
            tick; // N+2: RESP
            chk($sformatf("v%0d_cpu_ack", i), 32'(cpu_ack), 32'(!vecs[i].dma));
            chk($sformatf("v%0d_dma_ack", i), 32'(dma_ack), 32'(vecs[i].dma));
            chk($sformatf("v%0d_strobe_off", i), 32'(mem_rd | mem_we), 32'd0);
            if (!vecs[i].we)
                chk($sformatf("v%0d_rdata", i), 32'(vecs[i].dma ? dma_rdata : cpu_rdata), 32'(vecs[i].exp_rdata));
            cpu_req = 1'b0; dma_req = 1'b0;
            tick; // N+3: back in ARB
            chk($sformatf("v%0d_ack_off", i), 32'(cpu_ack | dma_ack), 32'd0);
            chk($sformatf("v%0d_busy0", i),   32'(busy), 32'd0);
            if (!vecs[i].we)
                chk($sformatf("v%0d_rdata_hold", i), 32'(vecs[i].dma ? dma_rdata : cpu_rdata), 32'(vecs[i].exp_rdata));
            $display("vec %0d: %s %s addr=%h data=%h", i, vecs[i].dma ? "DMA" : "CPU",
                     vecs[i].we ? "WR" : "RD", vecs[i].addr, vecs[i].we ? vecs[i].wdata : vecs[i].exp_rdata);
        end

        // ---------------- both requesting from reset, no lock ----------------
        do_reset;
        run_seq(1'b1, 1'b1, 1'b0, 6, 32'h0000_002A, "alt");

        // ---------------- locked DMA burst with CPU waiting ----------------
        do_reset;
        run_seq(1'b1, 1'b1, 1'b1, 10, 32'h0000_02FF, "burst");

        // ---------------- locked DMA alone, then CPU arrives ----------------
        do_reset;
        run_seq(1'b0, 1'b1, 1'b1, 12, 32'h0000_0FFF, "sat");
        run_seq(1'b1, 1'b1, 1'b1, 1, 32'h0000_0000, "sat_cpu");
        run_seq(1'b1, 1'b1, 1'b1, 1, 32'h0000_0001, "sat_dma");

        // ---------------- reset asserted during ACCESS ----------------
        do_reset;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h0005;
        tick;
        chk("rstacc_pre_rd", 32'(mem_rd), 32'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("rstacc_mem_rd", 32'(mem_rd),  32'd0);
        chk("rstacc_busy",   32'(busy),    32'd0);
        chk("rstacc_ack",    32'(cpu_ack), 32'd0);
        chk("rstacc_owner",  32'(owner),   32'd1);
        cpu_req = 1'b0;
        @(posedge clk);
        #1 reset_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick;
            chk($sformatf("rstacc_idle_ack%0d", k),  32'(cpu_ack | dma_ack), 32'd0);
            chk($sformatf("rstacc_idle_busy%0d", k), 32'(busy), 32'd0);
        end
        cpu_req = 1'b1;
        tick;
        chk("rstacc_new_rd", 32'(mem_rd), 32'd1);
        tick;
        chk("rstacc_new_ack", 32'(cpu_ack), 32'd1);
        cpu_req = 1'b0;
        tick;

        // ---------------- random traffic vs reference model ----------------
        do_reset;
        for (int i = 0; i < 16; i++) shadow[i] = slave_mem[i];
        m_owner = 1'b1; m_burst = 0; free_at = 0; p_valid = 1'b0;
        e_cpu_rdata = 8'h00; e_dma_rdata = 8'h00; ca = 1'b0; da = 1'b0; n_txn = 0;
        for (int t = 0; t < 1500; t++) begin
            tick;
            e_cpu_ack = p_valid && (t == p_ack_t) && !p_dma;
            e_dma_ack = p_valid && (t == p_ack_t) && p_dma;
            e_strobe  = p_valid && (t == p_ack_t - 1);
            if (e_cpu_ack && !p_we) e_cpu_rdata = p_rdata;
            if (e_dma_ack && !p_we) e_dma_rdata = p_rdata;
            chk("rnd_cpu_ack",   32'(cpu_ack),   32'(e_cpu_ack));
            chk("rnd_dma_ack",   32'(dma_ack),   32'(e_dma_ack));
            chk("rnd_mem_rd",    32'(mem_rd),    32'(e_strobe && !p_we));
            chk("rnd_mem_we",    32'(mem_we),    32'(e_strobe && p_we));
            chk("rnd_busy",      32'(busy),      32'(p_valid && (t >= p_ack_t - 1)));
            chk("rnd_owner",     32'(owner),     32'(m_owner));
            chk("rnd_cpu_rdata", 32'(cpu_rdata), 32'(e_cpu_rdata));
            chk("rnd_dma_rdata", 32'(dma_rdata), 32'(e_dma_rdata));
            if (e_strobe) chk("rnd_mem_addr", 32'(mem_addr), 32'(p_addr));
            if (e_strobe && p_we) chk("rnd_mem_wdata", 32'(mem_wdata), 32'(p_wdata));
            if (p_valid && (t == p_ack_t)) begin
                $display("rnd txn %0d: %s %s addr=%h data=%h", n_txn, p_dma ? "DMA" : "CPU",
                         p_we ? "WR" : "RD", p_addr, p_we ? p_wdata : p_rdata);
                n_txn++;
                p_valid = 1'b0;
            end

            // Master agents: hold a request until acked, then maybe issue another.
            if (cpu_ack) ca = 1'b0;
            if (!ca && ($urandom_range(0, 3) != 0)) begin
                ca = 1'b1;
                cpu_we = 1'($urandom_range(0, 1)); cpu_addr = 16'($urandom); cpu_wdata = 8'($urandom);
            end
            cpu_req = ca;
            if (dma_ack) da = 1'b0;
            if (!da && ($urandom_range(0, 3) != 0)) begin
                da = 1'b1;
                dma_we = 1'($urandom_range(0, 1)); dma_addr = 16'($urandom); dma_wdata = 8'($urandom);
            end
            dma_req  = da;
            dma_lock = ($urandom_range(0, 3) != 0);

            // Model: one access per three cycles, winner chosen by the rules.
            if ((t >= free_at) && (cpu_req || dma_req)) begin
                w = pick(cpu_req, dma_req, dma_lock, m_owner, m_burst);
                if (w) m_burst = (m_owner && dma_lock) ? ((m_burst < MAXB) ? m_burst + 1 : MAXB) : 0;
                else   m_burst = 0;
                m_owner = w;
                p_valid = 1'b1; p_dma = w; p_ack_t = t + 2; free_at = t + 3;
                p_we    = w ? dma_we : cpu_we;
                p_addr  = w ? dma_addr : cpu_addr;
                p_wdata = w ? dma_wdata : cpu_wdata;
                if (p_we) shadow[p_addr[3:0]] = p_wdata;
                else      p_rdata = shadow[p_addr[3:0]];
            end
        end
        chk("rnd_txn_seen", 32'(n_txn > 100), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
